ft2_fifo_bridge: RTL



---
 rtl/ft2_pkg.sv | 24 ++
 rtl/ft2_fifo_bridge_if.sv | 14 +
 rtl/ft2_sync_fifo.sv | 50 +++++
 rtl/ft2_fifo_bridge.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ft2_pkg.sv
// Shared types for the FT2232/FT245 FIFO-mode bridge: FSM states, arbitration
// direction constants and a constant-foldable clog2.
package ft2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_STROBE,
        RD_RECOVER,
        WR_SETUP,
        WR_STROBE,
        WR_RECOVER
    } ft2_state_e;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/ft2_fifo_bridge_if.sv
// User-side valid/ready byte streams of the FT FIFO bridge (rx: bridge->user, tx: user->bridge).
interface ft2_fifo_bridge_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (input rx_data, rx_valid, tx_ready, output rx_ready, tx_data, tx_valid);
    modport slave  (output rx_data, rx_valid, tx_ready, input rx_ready, tx_data, tx_valid);
endinterface

// File: rtl/ft2_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output; DEPTH must be a power of two.
module ft2_sync_fifo
    import ft2_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [DATA_W-1:0]       din,
    input  logic                    pop,
    output logic [DATA_W-1:0]       dout,
    output logic                    empty,
    output logic                    full,
    output logic [clog2(DEPTH):0]   level
);
    localparam int AW = clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign level = count;

endmodule

// File: rtl/ft2_fifo_bridge.sv
// FT2232/FT245 asynchronous FIFO-mode bridge with buffered rx/tx streams and runtime loopback.
// Optional FT2_BRIDGE_STATS_EN adds rx_count/tx_count byte counters.
module ft2_fifo_bridge
    import ft2_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int RD_PULSE    = 2,
    parameter int WR_SETUP    = 1,
    parameter int WR_PULSE    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          txe_n_in,
    input  logic                          rxf_n_in,
    output logic                          rd_n_out,
    output logic                          wr_n_out,
    inout  wire  [DATA_W-1:0]             ft_data,
    input  logic                          loopback_en,
    ft2_fifo_bridge_if.slave              user,
    output logic [clog2(FIFO_DEPTH):0]    rx_level,
    output logic [clog2(FIFO_DEPTH):0]    tx_level
`ifdef FT2_BRIDGE_STATS_EN
    ,
    output logic [31:0]                   rx_count,
    output logic [31:0]                   tx_count
`endif
);
    localparam int MAXP  = (RD_PULSE > WR_PULSE) ? ((RD_PULSE > WR_SETUP) ? RD_PULSE : WR_SETUP)
                                                 : ((WR_PULSE > WR_SETUP) ? WR_PULSE : WR_SETUP);
    localparam int CNT_W = clog2(MAXP) + 1;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_PULSE - 1);
    localparam logic [CNT_W-1:0] SU_LAST = CNT_W'(WR_SETUP - 1);
    localparam logic [CNT_W-1:0] WP_LAST = CNT_W'(WR_PULSE - 1);

    logic                   rst_n_sync;
    logic [SYNC_STAGES-1:0] rxf_sync, txe_sync;
    logic                   rxf_act, txe_act;
    ft2_state_e             state;
    logic [CNT_W-1:0]       cnt;
    logic                   drv_en, prio, lb_q;
    logic [DATA_W-1:0]      out_reg;
    logic                   rd_ok, wr_ok, go_wr;
    logic                   rx_push, rx_pop, rx_empty, rx_full;
    logic                   tx_push, tx_pop, tx_empty, tx_full, lb_xfer;
    logic [DATA_W-1:0]      rx_head, tx_head, tx_din;

    // Reset asserts asynchronously and releases on the next clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_n_sync <= 1'b0;
        else        rst_n_sync <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            rxf_sync <= '1;
            txe_sync <= '1;
        end else begin
            rxf_sync <= {rxf_sync[SYNC_STAGES-2:0], rxf_n_in};
            txe_sync <= {txe_sync[SYNC_STAGES-2:0], txe_n_in};
        end
    end

    assign rxf_act = ~rxf_sync[SYNC_STAGES-1];
    assign txe_act = ~txe_sync[SYNC_STAGES-1];
    assign wr_ok   = txe_act & ~tx_empty;
    assign rd_ok   = rxf_act & ~rx_full;
    assign go_wr   = wr_ok & (~rd_ok | (prio == DIR_WR));
    assign rx_push = (state == ft2_pkg::RD_STROBE) && (cnt == RD_LAST);
    assign tx_pop  = (state == ft2_pkg::WR_STROBE) && (cnt == WP_LAST);

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state    <= ft2_pkg::IDLE;
            cnt      <= '0;
            rd_n_out <= 1'b1;
            wr_n_out <= 1'b1;
            drv_en   <= 1'b0;
            prio     <= DIR_RD;
            lb_q     <= 1'b0;
        end else begin
            cnt <= cnt + CNT_W'(1);
            unique case (state)
                ft2_pkg::IDLE: begin
                    lb_q <= loopback_en;
                    cnt  <= '0;
                    if (go_wr) begin
                        drv_en <= 1'b1;
                        state  <= ft2_pkg::WR_SETUP;
                    end else if (rd_ok) begin
                        rd_n_out <= 1'b0;
                        state    <= ft2_pkg::RD_STROBE;
                    end
                end
                ft2_pkg::RD_STROBE: if (cnt == RD_LAST) begin
                    rd_n_out <= 1'b1;
                    cnt      <= '0;
                    state    <= ft2_pkg::RD_RECOVER;
                end
                ft2_pkg::RD_RECOVER: if (!rxf_act) begin
                    prio  <= DIR_WR;
                    cnt   <= '0;
                    state <= ft2_pkg::IDLE;
                end
                ft2_pkg::WR_SETUP: if (cnt == SU_LAST) begin
                    wr_n_out <= 1'b0;
                    cnt      <= '0;
                    state    <= ft2_pkg::WR_STROBE;
                end
                ft2_pkg::WR_STROBE: if (cnt == WP_LAST) begin
                    wr_n_out <= 1'b1;
                    cnt      <= '0;
                    state    <= ft2_pkg::WR_RECOVER;
                end
                // First recover cycle is the data hold; the driver drops after it.
                ft2_pkg::WR_RECOVER: begin
                    if (drv_en) begin
                        drv_en <= 1'b0;
                    end else if (!txe_act) begin
                        prio  <= DIR_RD;
                        cnt   <= '0;
                        state <= ft2_pkg::IDLE;
                    end
                end
                default: state <= ft2_pkg::IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == ft2_pkg::IDLE) && go_wr) out_reg <= tx_head;
    end

    assign ft_data = drv_en ? out_reg : {DATA_W{1'bz}};

    assign lb_xfer       = lb_q & ~rx_empty & ~tx_full;
    assign user.rx_data  = rx_head;
    assign user.rx_valid = rst_n_sync & ~lb_q & ~rx_empty;
    assign user.tx_ready = rst_n_sync & ~lb_q & ~tx_full;
    assign rx_pop        = lb_q ? lb_xfer : (user.rx_valid & user.rx_ready);
    assign tx_push       = lb_q ? lb_xfer : (user.tx_valid & user.tx_ready);
    assign tx_din        = lb_q ? rx_head : user.tx_data;

    ft2_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n_sync), .push(rx_push), .din(ft_data), .pop(rx_pop),
        .dout(rx_head), .empty(rx_empty), .full(rx_full), .level(rx_level)
    );

    ft2_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n_sync), .push(tx_push), .din(tx_din), .pop(tx_pop),
        .dout(tx_head), .empty(tx_empty), .full(tx_full), .level(tx_level)
    );

`ifdef FT2_BRIDGE_STATS_EN
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            if (rx_push) rx_count <= rx_count + 32'd1;
            if (tx_pop)  tx_count <= tx_count + 32'd1;
        end
    end
`endif

endmodule
